// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug-bus sweeper: FSM states, scan modes, record sources.
package dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      HOLD,
      FIN
   } state_t;

   localparam logic [1:0] MODE_RF   = 2'b00;
   localparam logic [1:0] MODE_MEM  = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;

   localparam logic SRC_RF  = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // The reserved encoding collapses onto an RF-only scan.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return (m == MODE_MEM || m == MODE_BOTH) ? m : MODE_RF;
   endfunction

endpackage

// File: rtl/dbg_out_reg.sv
// Record holding register: loads in one cycle, holds fields stable until valid & ready.
// A clear drops a pending record immediately; the data fields are left as they were.
module dbg_out_reg
   import dbg_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_clr,
   input  logic          i_src,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   input  logic          i_ready,
   output logic          o_valid,
   output logic          o_src,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic          r_src;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_src   <= SRC_RF;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_src   <= i_src;
         r_addr  <= i_addr;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_src   = r_src;
   assign o_addr  = r_addr;
   assign o_data  = r_data;

endmodule

// File: rtl/dbg_scan_ctrl.sv
// Debug-bus sweeper: walks RF and/or memory addresses, samples after RD_LAT cycles, streams records.
// First record RD_LAT+1 cycles after start; the scan stalls in HOLD while out_ready is low.
module dbg_scan_ctrl
   import dbg_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 8,
   parameter int RF_N   = 32,
   parameter int MEM_N  = 256,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   output logic [AW-1:0] m_rf_addr,
   input  logic [DW-1:0] rf_data,
   input  logic [DW-1:0] m_data,
   input  logic [DW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] scan_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_src,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data
);

   localparam logic [3:0]  LAT     = 4'(RD_LAT);
   localparam logic [AW:0] RF_LAST  = (AW+1)'(RF_N - 1);
   localparam logic [AW:0] MEM_LAST = (AW+1)'(MEM_N - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] w_addr_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic          r_pass;
   logic          w_pass_nxt;
   logic          r_both;
   logic          w_both_nxt;
   logic [DW-1:0] r_scan_pc;
   logic [DW-1:0] w_pc_nxt;
   logic          w_load;
   logic          w_clr;
   logic          w_hs;
   logic          w_last;
   logic [1:0]    w_mode;
   logic [DW-1:0] w_smp;

   assign w_mode = eff_mode(mode);
   assign w_last = ({1'b0, r_addr} == ((r_pass == SRC_MEM) ? MEM_LAST : RF_LAST));
   assign w_smp  = (r_pass == SRC_MEM) ? m_data : rf_data;
   assign w_hs   = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_pass    <= SRC_RF;
         r_both    <= 1'b0;
         r_scan_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pass    <= w_pass_nxt;
         r_both    <= w_both_nxt;
         r_scan_pc <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_pass_nxt  = r_pass;
      w_both_nxt  = r_both;
      w_pc_nxt    = r_scan_pc;
      w_load      = 1'b0;
      w_clr       = 1'b0;
      if (abort && r_state != IDLE) begin
         w_state_nxt = IDLE;
         w_addr_nxt  = '0;
         w_clr       = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  w_state_nxt = SETTLE;
                  w_pc_nxt    = pc;
                  w_both_nxt  = (w_mode == MODE_BOTH);
                  w_pass_nxt  = (w_mode == MODE_MEM) ? SRC_MEM : SRC_RF;
                  w_addr_nxt  = '0;
                  w_cnt_nxt   = LAT;
               end
            end
            SETTLE: begin
               if (r_cnt <= 4'd1) w_state_nxt = SAMPLE;
               else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            SAMPLE: begin
               w_load      = 1'b1;
               w_state_nxt = HOLD;
            end
            HOLD: begin
               if (w_hs) begin
                  if (!w_last) begin
                     w_addr_nxt  = r_addr + AW'(1);
                     w_cnt_nxt   = LAT;
                     w_state_nxt = SETTLE;
                  end else if (r_pass == SRC_RF && r_both) begin
                     w_pass_nxt  = SRC_MEM;
                     w_addr_nxt  = '0;
                     w_cnt_nxt   = LAT;
                     w_state_nxt = SETTLE;
                  end else begin
                     w_state_nxt = FIN;
                  end
               end
            end
            FIN: begin
               w_addr_nxt  = '0;
               w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
               w_addr_nxt  = '0;
            end
         endcase
      end
   end

   dbg_out_reg #(
      .DW(DW),
      .AW(AW)
   ) u_out_reg (
      .clk    (clk),
      .rst_n  (rst),
      .i_load (w_load),
      .i_clr  (w_clr),
      .i_src  (r_pass),
      .i_addr (r_addr),
      .i_data (w_smp),
      .i_ready(out_ready),
      .o_valid(out_valid),
      .o_src  (out_src),
      .o_addr (out_addr),
      .o_data (out_data)
   );

   assign m_rf_addr = r_addr;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == FIN);
   assign scan_pc   = r_scan_pc;

endmodule
